// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 serial receiver feeding a first-word-fall-through byte FIFO
// Bytes are pushed mid stop bit so a back-to-back start edge is never missed.
module uart_rx_fifo #(
   parameter int clks_per_bit = 867,
   parameter int buffer_depth = 8
) (
   input  logic                            reset,
   input  logic                            clock,
   input  logic                            uart_rx,
   output logic [7:0]                      rx_data,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   output logic [$clog2(buffer_depth):0]   rx_count,
   output logic                            overrun,
   output logic                            frame_error,
   input  logic                            err_clear
);

   localparam int AW = $clog2(buffer_depth);
   localparam int CW = $clog2(clks_per_bit + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(clks_per_bit);
   localparam logic [CW-1:0] CNT_HALF = CW'(clks_per_bit / 2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic          rx_meta_q, rxs_q;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          stop_ok, stop_bad;

   logic [7:0]    mem_q [buffer_depth];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          full, pop, push, overrun_set;
   logic          overrun_q, overrun_d, frame_error_q, frame_error_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rxs_q     <= rx_meta_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = rxs_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            // Counter restarts after every sample so each bit centre is a full period apart.
            if (cnt_q == CNT_FULL) begin
               cnt_d          = '0;
               shift_d[bit_q] = rxs_q;
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d    = '0;
               state_d  = S_IDLE;
               stop_ok  = rxs_q;
               stop_bad = !rxs_q;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop         = rx_valid && rx_ready;
   assign push        = stop_ok && (!full || pop);
   assign overrun_set = stop_ok && full && !pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
   end

   assign rx_count = wr_ptr_q - rd_ptr_q;
   assign rx_valid = (wr_ptr_q != rd_ptr_q);
   assign rx_data  = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;

   // A set event in the same cycle as err_clear must survive the clear.
   assign overrun_d     = overrun_set || (overrun_q && !err_clear);
   assign frame_error_d = stop_bad || (frame_error_q && !err_clear);

   always_ff @(posedge clock) begin
      if (reset) begin
         overrun_q     <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         overrun_q     <= overrun_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign overrun     = overrun_q;
   assign frame_error = frame_error_q;

endmodule
